stim_seq: RTL

STIM_SEQ -- requirements
Module: stim_seq

---
 rtl/stim_seq_pkg.sv | 12 +
 rtl/stepcnt.sv | 41 ++++
 rtl/stim_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/stim_seq_pkg.sv
// Shared types and defaults for the stim_seq word generator.
package stim_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  localparam int STIM_SEQ_N_DEF = 4;

endpackage

// File: rtl/stepcnt.sv
// N-bit step counter with synchronous clear, enable, and terminal-count flag.
// Enabling the counter at the terminal count wraps it back to zero.
module stepcnt #(
  parameter int            N     = 4,
  parameter logic [N-1:0]  LIMIT = {N{1'b1}}
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [N-1:0] q_o,
  output logic         tc_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic         tc;

  assign tc = (q_q == LIMIT);

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = tc ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o  = q_q;
  assign tc_o = tc;

endmodule

// File: rtl/stim_seq.sv
// Stimulus word sequencer: emits X=0..LIMIT under a valid/ready handshake.
// Define STIM_SEQ_WRAP_EN to wrap X back to 0 at LIMIT instead of finishing.
module stim_seq
  import stim_seq_pkg::*;
#(
  parameter int           N     = STIM_SEQ_N_DEF,
  parameter logic [N-1:0] LIMIT = {N{1'b1}}
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         STOP,
  input  logic         READY,
  output logic [N-1:0] X,
  output logic         VALID,
  output logic         DONE,
  output logic [N:0]   XFER_CNT
);

  state_t       state_q, state_d;
  logic         valid_q, valid_d;
  logic         done_q,  done_d;
  logic [N:0]   cnt_q,   cnt_d;
  logic         x_clr;
  logic         x_en;
  logic         x_tc;
  logic         xfer;

  function automatic logic [N:0] sat_inc(input logic [N:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign xfer = valid_q & READY;

  stepcnt #(
    .N     (N),
    .LIMIT (LIMIT)
  ) u_xcnt (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (x_clr),
    .en_i  (x_en),
    .q_o   (X),
    .tc_o  (x_tc)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    x_clr   = 1'b0;
    x_en    = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (!STOP && START) begin
          state_d = RUN;
          valid_d = 1'b1;
          x_clr   = 1'b1;
          cnt_d   = '0;
        end
      end

      RUN: begin
        valid_d = 1'b1;
        done_d  = 1'b0;
        // STOP discards any transfer offered on the same edge
        if (STOP) begin
          state_d = IDLE;
          valid_d = 1'b0;
          x_clr   = 1'b1;
        end else if (xfer) begin
          cnt_d = sat_inc(cnt_q);
`ifdef STIM_SEQ_WRAP_EN
          x_en  = 1'b1;
`else
          if (x_tc) begin
            state_d = DONE_ST;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_en = 1'b1;
          end
`endif
        end
      end

      DONE_ST: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        if (STOP) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else if (START) begin
          state_d = RUN;
          valid_d = 1'b1;
          done_d  = 1'b0;
          x_clr   = 1'b1;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign VALID    = valid_q;
  assign DONE     = done_q;
  assign XFER_CNT = cnt_q;

endmodule
